// File: rtl/double_to_float_pkg.sv
// Shared fpu definitions for the double_to_float converter: FSM encoding,
// IEEE-754 bias and field-width constants, and the canonical single NaN.
package double_to_float_pkg;

    typedef enum logic [2:0] {
        ST_GET_A,
        ST_UNPACK,
        ST_SPECIAL,
        ST_NORMALISE,
        ST_ROUND,
        ST_PACK,
        ST_PUT_Z
    } state_t;

    localparam int DBL_BIAS   = 1023;
    localparam int SGL_BIAS   = 127;
    localparam int DBL_MANT_W = 52;
    localparam int DBL_EXP_W  = 11;
    localparam int SGL_MANT_W = 23;
    localparam int SGL_EXP_W  = 8;

    localparam logic [31:0] CANON_NAN_SGL = 32'hFFC00000;

endpackage

// File: rtl/double_to_float.sv
// Double-to-single converter, round-to-nearest-even, stb/ack handshake both sides;
// result stb at E3 (special) / E6 (normal) / E6+k (denormal); DOUBLE_TO_FLOAT_FTZ_EN flushes subnormals.
module double_to_float
    import double_to_float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    localparam logic signed [12:0] E_SPECIAL  = 13'sd1024;
    localparam logic signed [12:0] E_ZERO     = -13'sd1023;
    localparam logic signed [12:0] E_MAX      = 13'sd127;
    localparam logic signed [12:0] E_MIN_NORM = -13'sd126;
`ifndef DOUBLE_TO_FLOAT_FTZ_EN
    localparam logic signed [12:0] E_MIN_SUB  = -13'sd151;
`endif

    state_t             state_q, state_d;
    logic [63:0]        a_q, a_d;
    logic               s_q, s_d;
    logic signed [12:0] e_q, e_d;
    logic [51:0]        m_q, m_d;
    logic [23:0]        z_m_q, z_m_d;
    logic signed [12:0] z_e_q, z_e_d;
    logic               guard_q, guard_d;
    logic               round_q, round_d;
    logic               sticky_q, sticky_d;
    logic [31:0]        z_q, z_d;
    logic               ack_q, ack_d;
    logic               stb_q, stb_d;
    logic [SGL_EXP_W-1:0] pack_exp;

    // Low 8 bits of the unbiased exponent plus bias wraps correctly for -126..127.
    assign pack_exp = z_e_q[SGL_EXP_W-1:0] + SGL_EXP_W'(SGL_BIAS);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        s_d      = s_q;
        e_d      = e_q;
        m_d      = m_q;
        z_m_d    = z_m_q;
        z_e_d    = z_e_q;
        guard_d  = guard_q;
        round_d  = round_q;
        sticky_d = sticky_q;
        z_d      = z_q;
        ack_d    = ack_q;
        stb_d    = stb_q;

        unique case (state_q)
            ST_GET_A: begin
                ack_d = 1'b1;
                if (ack_q && input_a_stb) begin
                    a_d     = input_a;
                    ack_d   = 1'b0;
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                s_d     = a_q[63];
                e_d     = $signed({2'b00, a_q[DBL_MANT_W +: DBL_EXP_W]}) - $signed(13'(DBL_BIAS));
                m_d     = a_q[DBL_MANT_W-1:0];
                state_d = ST_SPECIAL;
            end
            ST_SPECIAL: begin
                state_d = ST_PUT_Z;
                if (e_q == E_SPECIAL && m_q != '0) begin
                    z_d = CANON_NAN_SGL;
                end else if (e_q == E_SPECIAL) begin
                    z_d = {s_q, 8'hFF, 23'h0};
                end else if (e_q == E_ZERO) begin
                    z_d = {s_q, 31'h0};
                end else if (e_q > E_MAX) begin
                    z_d = {s_q, 8'hFF, 23'h0};
`ifdef DOUBLE_TO_FLOAT_FTZ_EN
                end else if (e_q < E_MIN_NORM) begin
`else
                end else if (e_q < E_MIN_SUB) begin
`endif
                    z_d = {s_q, 31'h0};
                end else begin
                    z_m_d    = {1'b1, m_q[DBL_MANT_W-1 -: SGL_MANT_W]};
                    guard_d  = m_q[28];
                    round_d  = m_q[27];
                    sticky_d = |m_q[26:0];
                    z_e_d    = e_q;
                    state_d  = ST_NORMALISE;
                end
            end
            ST_NORMALISE: begin
                // One right shift per cycle until the exponent reaches the denormal floor.
                if (z_e_q < E_MIN_NORM) begin
                    z_e_d    = z_e_q + 13'sd1;
                    z_m_d    = z_m_q >> 1;
                    guard_d  = z_m_q[0];
                    round_d  = guard_q;
                    sticky_d = sticky_q | round_q;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
                    z_m_d = z_m_q + 24'd1;
                    if (z_m_q == 24'hFFFFFF) begin
                        z_e_d = z_e_q + 13'sd1;
                    end
                end
                state_d = ST_PACK;
            end
            ST_PACK: begin
                z_d = {s_q, pack_exp, z_m_q[SGL_MANT_W-1:0]};
                if (z_e_q == E_MIN_NORM && !z_m_q[23]) begin
                    z_d[30:23] = 8'h00;
                end
                if (z_e_q > E_MAX) begin
                    z_d = {s_q, 8'hFF, 23'h0};
                end
                state_d = ST_PUT_Z;
            end
            ST_PUT_Z: begin
                stb_d = 1'b1;
                if (stb_q && output_z_ack) begin
                    stb_d   = 1'b0;
                    state_d = ST_GET_A;
                end
            end
            default: begin
                state_d = ST_GET_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_GET_A;
            a_q      <= '0;
            s_q      <= 1'b0;
            e_q      <= '0;
            m_q      <= '0;
            z_m_q    <= '0;
            z_e_q    <= '0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            z_q      <= '0;
            ack_q    <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            s_q      <= s_d;
            e_q      <= e_d;
            m_q      <= m_d;
            z_m_q    <= z_m_d;
            z_e_q    <= z_e_d;
            guard_q  <= guard_d;
            round_q  <= round_d;
            sticky_q <= sticky_d;
            z_q      <= z_d;
            ack_q    <= ack_d;
            stb_q    <= stb_d;
        end
    end

    assign input_a_ack  = ack_q;
    assign output_z_stb = stb_q;
    assign output_z     = z_q;

endmodule

// File: tb/tb_double_to_float.sv
// Directed-vector bench for double_to_float: value and latency table, then
// back-pressure and reset-during-normalise sequences.
module tb_double_to_float;

    logic        clk;
    logic        rst;
    logic [63:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    int errors = 0;
    int checks = 0;

    double_to_float dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [31:0] z;
        int          lat;
        string       name;
    } vec_t;

    localparam int NV = 9;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns at the negedge-side of the transfer edge plus 1 time unit.
    task automatic send(input logic [63:0] a);
        int n;
        n = 0;
        @(negedge clk);
        while (!input_a_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!input_a_ack) chk("send_timeout", 64'd0, 64'd1);
        input_a     = a;
        input_a_stb = 1'b1;
        @(posedge clk);
        #1 input_a_stb = 1'b0;
    endtask

    // Counts active edges after the input transfer edge until stb is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!output_z_stb && lat < 80);
        if (!output_z_stb) chk("result_timeout", 64'd0, 64'd1);
    endtask

    task automatic release_ack(input string name);
        output_z_ack = 1'b1;
        @(posedge clk);
        #1 output_z_ack = 1'b0;
        @(negedge clk);
        chk({name, "_stb_fall"}, 64'(output_z_stb), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  stale;

        vec[0] = '{64'h3FF0000000000000, 32'h3F800000, 6, "one"};
        vec[1] = '{64'h7FF8000000000000, 32'hFFC00000, 3, "nan"};
        vec[2] = '{64'hFFF0000000000000, 32'hFF800000, 3, "neg_inf"};
        vec[3] = '{64'h8000000000000000, 32'h80000000, 3, "neg_zero"};
        vec[4] = '{64'h3FF0000010000000, 32'h3F800000, 6, "tie_even"};
        vec[5] = '{64'h3FF0000030000000, 32'h3F800002, 6, "round_up"};
        vec[6] = '{64'h47EFFFFFF0000000, 32'h7F800000, 6, "round_ovf"};
`ifdef DOUBLE_TO_FLOAT_FTZ_EN
        vec[7] = '{64'h36A0000000000000, 32'h00000000, 3, "min_denorm"};
        vec[8] = '{64'h3690000000000000, 32'h00000000, 3, "half_min"};
`else
        vec[7] = '{64'h36A0000000000000, 32'h00000001, 29, "min_denorm"};
        vec[8] = '{64'h3690000000000000, 32'h00000000, 30, "half_min"};
`endif

        rst          = 1'b1;
        input_a      = '0;
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 64'(input_a_ack), 64'd0);
        chk("rst_stb", 64'(output_z_stb), 64'd0);
        chk("rst_z", 64'(output_z), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ack_after_rst", 64'(input_a_ack), 64'd1);

        for (int i = 0; i < NV; i++) begin
            send(vec[i].a);
            wait_result(lat);
            chk({vec[i].name, "_z"}, 64'(output_z), 64'(vec[i].z));
            chk({vec[i].name, "_lat"}, 64'(lat), 64'(vec[i].lat));
            release_ack(vec[i].name);
        end

        // Back-pressure: result and handshake state must hold while ack is low.
        send(64'h3FF0000000000000);
        wait_result(lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_stb", 64'(output_z_stb), 64'd1);
            chk("bp_z", 64'(output_z), 64'h3F800000);
            chk("bp_in_ack", 64'(input_a_ack), 64'd0);
        end
        output_z_ack = 1'b1;
        @(posedge clk);
        #1 output_z_ack = 1'b0;
        @(negedge clk);
        chk("bp_stb_fall", 64'(output_z_stb), 64'd0);
        chk("bp_ack_still_low", 64'(input_a_ack), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_ack_rise", 64'(input_a_ack), 64'd1);

        // Reset while the denormal shift loop is running.
        send(64'h36A0000000000000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_stb", 64'(output_z_stb), 64'd0);
        chk("mid_rst_ack", 64'(input_a_ack), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ack_rise", 64'(input_a_ack), 64'd1);
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (output_z_stb) stale = 1'b1;
        end
        chk("no_stale_result", 64'(stale), 64'd0);
        send(64'h3FF0000030000000);
        wait_result(lat);
        chk("post_rst_z", 64'(output_z), 64'h3F800002);
        chk("post_rst_lat", 64'(lat), 64'd6);
        release_ack("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
